// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back skid buffer.
// State encoding, default widths and the mux source tags live here.
package wb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int unsigned DATA_W_DEF = 18;
    localparam int unsigned TAG_W_DEF  = 2;
    localparam int unsigned CNT_W      = 8;

    localparam logic [1:0] SRC_A = 2'b00;
    localparam logic [1:0] SRC_B = 2'b01;
    localparam logic [1:0] SRC_C = 2'b10;
    localparam logic [1:0] SRC_D = 2'b11;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/wb_skid_buffer_if.sv
// Valid/ready bundle between the mux, the skid buffer and the write-back consumer.
// slave is the buffer's view; master is the upstream/consumer view driving it.
interface wb_skid_buffer_if
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
);
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data,
        input  in_tag,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_tag,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_tag,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_tag,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/wb_skid_buffer.sv
// Two-entry registered skid buffer between the operand mux and the write-back stage.
// Handshake outputs decode from registered state only, so out_ready never reaches in_ready.
module wb_skid_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_skid_buffer_if.slave       bus,
    output logic [CNT_W-1:0]      drop_cnt
);

    state_e state_q, state_d;

    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [TAG_W-1:0]  main_tag_q,  skid_tag_q;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic in_ready, out_valid;
    logic in_fire, out_fire;
    logic load_main, main_from_skid, load_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head register: only written on a fire, so X on idle inputs never lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_tag_q  <= '0;
        end else if (load_main) begin
            main_data_q <= main_from_skid ? skid_data_q : bus.in_data;
            main_tag_q  <= main_from_skid ? skid_tag_q  : bus.in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else if (load_skid) begin
            skid_data_q <= bus.in_data;
            skid_tag_q  <= bus.in_tag;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (bus.in_valid && !in_ready) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_tag   = main_tag_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_wb_skid_buffer.sv
// Scoreboard bench for wb_skid_buffer: stimulus queues accepted words, a negedge monitor
// pops and compares every delivered word, checks stall stability and a drop counter model.
module tb_wb_skid_buffer
    import wb_pkg::*;
;
    localparam int unsigned DW = 18;
    localparam int unsigned TW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW+TW-1:0] exp_q[$];

    wb_skid_buffer_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    wb_skid_buffer #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) begin
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
            end
        end
    endtask

    // Monitor: delivered-word scoreboard, stall stability and drop counter model.
    int unsigned      drop_model = 0;
    logic             prev_stall = 1'b0;
    logic [DW+TW-1:0] prev_word = '0;

    always @(negedge clk) begin
        logic [DW+TW-1:0] exp_w;
        if (!rst_n) begin
            drop_model = 0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            check("drop_cnt_model", {24'd0, drop_cnt}, drop_model);
            if (prev_stall) begin
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_word", {12'd0, bus.out_data, bus.out_tag}, {12'd0, prev_word});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {12'd0, bus.out_data, bus.out_tag}, 32'hDEAD_BEEF);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_data", {14'd0, bus.out_data}, {14'd0, exp_w[DW+TW-1:TW]});
                    check("out_tag", {30'd0, bus.out_tag}, {30'd0, exp_w[TW-1:0]});
                end
            end
            if (bus.in_valid && !bus.in_ready && drop_model < 255) begin
                drop_model++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_data, bus.out_tag};
        end
    end

    // Drive one cycle at posedge+1, queue the word if it will fire, then advance.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [TW-1:0] t,
                         input logic r);
        bus.in_valid  = v;
        bus.in_data   = v ? d : 'x;
        bus.in_tag    = v ? t : 'x;
        bus.out_ready = r;
        if (v && bus.in_ready) begin
            exp_q.push_back({d, t});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] pt_data [4];
        logic [TW-1:0] pt_tag  [4];
        pt_data = '{18'h01234, 18'h05678, 18'h09ABC, 18'h0DEF0};
        pt_tag  = '{SRC_A, SRC_B, SRC_C, SRC_D};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_data", {14'd0, bus.out_data}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through with no bubbles.
        for (int i = 0; i < 4; i++) begin
            check("pt_in_ready", {31'd0, bus.in_ready}, 32'd1);
            drive(1'b1, pt_data[i], pt_tag[i], 1'b1);
            check("pt_latency", {14'd0, bus.out_data}, {14'd0, pt_data[i]});
            check("pt_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        drive(1'b0, '0, '0, 1'b1);
        check("pt_drained", {31'd0, bus.out_valid}, 32'd0);

        // Back-pressure: two accepted, third dropped.
        drive(1'b1, 18'h00011, SRC_A, 1'b0);
        check("bp_ready_one", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, 18'h00022, SRC_B, 1'b0);
        check("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 18'h00033, SRC_C, 1'b0);
        check("bp_drop1", {24'd0, drop_cnt}, 32'd1);
        check("bp_head_held", {14'd0, bus.out_data}, 32'h00011);
        drive(1'b0, '0, '0, 1'b1);
        check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
        check("bp_second", {14'd0, bus.out_data}, 32'h00022);
        drive(1'b0, '0, '0, 1'b1);
        check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Simultaneous in/out fire while ONE.
        drive(1'b1, 18'h3FFFF, SRC_D, 1'b0);
        drive(1'b1, 18'h00001, SRC_A, 1'b1);
        check("sim_data", {14'd0, bus.out_data}, 32'h00001);
        check("sim_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("sim_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b0, '0, '0, 1'b1);

        // Saturation: fill, then hammer while FULL.
        drive(1'b1, 18'h00AAA, SRC_B, 1'b0);
        drive(1'b1, 18'h00BBB, SRC_C, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 18'h12345, SRC_D, 1'b0);
        end
        check("sat_255", {24'd0, drop_cnt}, 32'd255);

        // Asynchronous reset mid-cycle while FULL.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("arst_out_data", {14'd0, bus.out_data}, 32'd0);
        check("arst_out_tag", {30'd0, bus.out_tag}, 32'd0);
        check("arst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", {31'd0, bus.out_valid}, 32'd0);

        // Random traffic; the monitor does the checking.
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 9) < 6), DW'($urandom), TW'($urandom), 
                  ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b1);
        end
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_out_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
